// File: rtl/contador_pkg.sv
// Shared constants, types and helpers for the cascaded BCD counter.
//   DIGIT_W  : bits per BCD digit
//   DEC_MOD  : modulus of every digit except the most significant one
//   digit_t  : one BCD digit
//   sat_digit: clamps a loaded digit to the largest legal value of that digit
package contador_pkg;

    localparam int DIGIT_W = 4;
    localparam int DEC_MOD = 10;

    typedef logic [DIGIT_W-1:0] digit_t;

    // Out-of-range load values clamp to the digit maximum (modulus-1).
    function automatic digit_t sat_digit(input digit_t d, input digit_t max_v);
        return (d > max_v) ? max_v : d;
    endfunction

endpackage

// File: rtl/contador_bcd_n_if.sv
// Control/data bundle of the BCD counter.
//   loadn  : synchronous parallel load, active-low
//   enable : count enable, active-high
//   up     : direction, 1 = up, 0 = down
//   data   : load value, packed BCD, digit 0 in [3:0]
//   count  : current value, packed BCD, registered
//   tc     : terminal count (combinational, for cascading)
//   zero   : count is all zeros (combinational)
//   done   : sticky "down count reached zero" flag, registered
// master modport drives the controls; slave modport is the counter side.
interface contador_bcd_n_if
    import contador_pkg::*;
#(
    parameter int N_DIGITS = 2
);
    logic                        loadn;
    logic                        enable;
    logic                        up;
    logic [DIGIT_W*N_DIGITS-1:0] data;
    logic [DIGIT_W*N_DIGITS-1:0] count;
    logic                        tc;
    logic                        zero;
    logic                        done;

    modport master (
        output loadn, enable, up, data,
        input  count, tc, zero, done
    );

    modport slave (
        input  loadn, enable, up, data,
        output count, tc, zero, done
    );
endinterface

// File: rtl/contador_digito.sv
// One BCD digit of modulus MOD with synchronous clear, saturating load and
// wrap-around increment/decrement.
//   clock   : rising-edge clock
//   clr     : synchronous clear, active-high (highest priority)
//   load    : load d (clamped to MOD-1), beats inc/dec
//   d       : load value
//   inc/dec : step up/down this edge (inc wins if both are set)
//   q       : registered digit value
//   at_max  : q == MOD-1
//   at_zero : q == 0
module contador_digito
    import contador_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic   clock,
    input  logic   clr,
    input  logic   load,
    input  digit_t d,
    input  logic   inc,
    input  logic   dec,
    output digit_t q,
    output logic   at_max,
    output logic   at_zero
);

    localparam digit_t MAX_V = digit_t'(MOD - 1);

    digit_t q_r;

    // Digit register: clear > load > increment > decrement > hold.
    always_ff @(posedge clock) begin
        if (clr) begin
            q_r <= 4'd0;
        end else if (load) begin
            q_r <= sat_digit(d, MAX_V);
        end else if (inc) begin
            q_r <= (q_r == MAX_V) ? 4'd0 : q_r + 4'd1;
        end else if (dec) begin
            q_r <= (q_r == 4'd0) ? MAX_V : q_r - 4'd1;
        end else begin
            q_r <= q_r;
        end
    end

    assign q       = q_r;
    assign at_max  = (q_r == MAX_V);
    assign at_zero = (q_r == 4'd0);

endmodule

// File: rtl/contador_bcd_n.sv
// N-digit up/down BCD counter with saturating parallel load, optional hold
// at zero on down count, terminal-count output and a sticky "done" flag.
//   clock : rising-edge clock
//   clr   : synchronous clear, active-high, beats load and count
//   bus   : slave side of contador_bcd_n_if (loadn, enable, up, data in;
//           count, tc, zero, done out)
// Parameters: N_DIGITS (1..8), MOD_MSD (2..10, modulus of the top digit),
// STOP_AT_ZERO (1 = down count holds at 0, 0 = wraps to max).
module contador_bcd_n
    import contador_pkg::*;
#(
    parameter int N_DIGITS     = 2,
    parameter int MOD_MSD      = 6,
    parameter int STOP_AT_ZERO = 1
) (
    input  logic               clock,
    input  logic               clr,
    contador_bcd_n_if.slave    bus
);

    logic [DIGIT_W*N_DIGITS-1:0] count_s;
    logic [N_DIGITS-1:0]         at_max_s;
    logic [N_DIGITS-1:0]         at_zero_s;
    logic [N_DIGITS-1:0]         inc_s;
    logic [N_DIGITS-1:0]         dec_s;
    // chain[k] = all digits below k are at max / at zero; chain[N] covers all.
    logic [N_DIGITS:0]           max_chain_s;
    logic [N_DIGITS:0]           zero_chain_s;
    logic                        step_s;
    logic                        hold_zero_s;
    logic                        upper_zero_s;
    logic                        count_one_s;
    logic                        done_r;

    // Carry/borrow chain and per-digit step strobes.
    always_comb begin
        max_chain_s[0]  = 1'b1;
        zero_chain_s[0] = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            max_chain_s[k+1]  = max_chain_s[k] & at_max_s[k];
            zero_chain_s[k+1] = zero_chain_s[k] & at_zero_s[k];
        end

        // A load on the same edge suppresses counting entirely.
        step_s      = bus.enable & bus.loadn;
        hold_zero_s = (STOP_AT_ZERO != 0) ? zero_chain_s[N_DIGITS] : 1'b0;

        inc_s = '0;
        dec_s = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            inc_s[k] = step_s & bus.up & max_chain_s[k];
            dec_s[k] = step_s & ~bus.up & zero_chain_s[k] & ~hold_zero_s;
        end
    end

    // Value == 1 detection: the only state whose down step lands on zero.
    always_comb begin
        upper_zero_s = 1'b1;
        for (int k = 1; k < N_DIGITS; k++) begin
            upper_zero_s = upper_zero_s & at_zero_s[k];
        end
        count_one_s = (count_s[DIGIT_W-1:0] == 4'd1) & upper_zero_s;
    end

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        localparam int DIG_MOD = (k == N_DIGITS - 1) ? MOD_MSD : DEC_MOD;

        contador_digito #(
            .MOD (DIG_MOD)
        ) u_digito (
            .clock   (clock),
            .clr     (clr),
            .load    (~bus.loadn),
            .d       (bus.data[k*DIGIT_W +: DIGIT_W]),
            .inc     (inc_s[k]),
            .dec     (dec_s[k]),
            .q       (count_s[k*DIGIT_W +: DIGIT_W]),
            .at_max  (at_max_s[k]),
            .at_zero (at_zero_s[k])
        );
    end

    // Sticky done: set on a 1 -> 0 down step, cleared by clr or any load.
    always_ff @(posedge clock) begin
        if (clr) begin
            done_r <= 1'b0;
        end else if (!bus.loadn) begin
            done_r <= 1'b0;
        end else if (bus.enable && !bus.up && count_one_s) begin
            done_r <= 1'b1;
        end else begin
            done_r <= done_r;
        end
    end

    assign bus.count = count_s;
    assign bus.zero  = zero_chain_s[N_DIGITS];
    assign bus.tc    = bus.enable &
                       (bus.up ? max_chain_s[N_DIGITS] : zero_chain_s[N_DIGITS]);
    assign bus.done  = done_r;

endmodule

// File: tb/tb_contador_bcd_n.sv
// Scoreboard bench for contador_bcd_n (N_DIGITS=2, MOD_MSD=6).
// dut0 holds at zero on down count, dut1 wraps.
module tb_contador_bcd_n;

    typedef struct packed {
        logic [7:0] count;
        logic       tc;
        logic       zero;
        logic       done;
    } obs_t;

    logic clk;
    logic clr0;
    logic clr1;
    int   checks;
    int   failures;

    obs_t  exp_q[$];
    logic  sel_q[$];
    string name_q[$];

    contador_bcd_n_if #(.N_DIGITS(2)) bus0 ();
    contador_bcd_n_if #(.N_DIGITS(2)) bus1 ();

    contador_bcd_n #(.N_DIGITS(2), .MOD_MSD(6), .STOP_AT_ZERO(1)) dut0 (
        .clock (clk),
        .clr   (clr0),
        .bus   (bus0)
    );

    contador_bcd_n #(.N_DIGITS(2), .MOD_MSD(6), .STOP_AT_ZERO(0)) dut1 (
        .clock (clk),
        .clr   (clr1),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the DUT presents a new value after every edge; compare it at
    // the following falling edge against the oldest queued expectation.
    always @(negedge clk) begin
        obs_t  e;
        obs_t  a;
        logic  s;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            s = sel_q.pop_front();
            n = name_q.pop_front();
            if (s)
                a = {bus1.count, bus1.tc, bus1.zero, bus1.done};
            else
                a = {bus0.count, bus0.tc, bus0.zero, bus0.done};
            checks = checks + 1;
            if (a !== e) begin
                failures = failures + 1;
                $display("FAIL %s: got count=%h tc=%b zero=%b done=%b, want count=%h tc=%b zero=%b done=%b",
                         n, a.count, a.tc, a.zero, a.done, e.count, e.tc, e.zero, e.done);
            end
        end
    end

    // Apply one edge worth of stimulus to the selected DUT (the other idles)
    // and queue the response expected right after that edge.
    task automatic step(input logic sel, input logic c, input logic ldn,
                        input logic en, input logic u, input logic [7:0] d,
                        input logic [7:0] ec, input logic etc, input logic ez,
                        input logic ed, input string nm);
        obs_t e;
        clr0 = 1'b0; bus0.loadn = 1'b1; bus0.enable = 1'b0; bus0.up = 1'b1; bus0.data = 8'h00;
        clr1 = 1'b0; bus1.loadn = 1'b1; bus1.enable = 1'b0; bus1.up = 1'b1; bus1.data = 8'h00;
        if (sel) begin
            clr1 = c; bus1.loadn = ldn; bus1.enable = en; bus1.up = u; bus1.data = d;
        end else begin
            clr0 = c; bus0.loadn = ldn; bus0.enable = en; bus0.up = u; bus0.data = d;
        end
        @(posedge clk);
        e = '{count: ec, tc: etc, zero: ez, done: ed};
        exp_q.push_back(e);
        sel_q.push_back(sel);
        name_q.push_back(nm);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        clr0 = 1'b0; clr1 = 1'b0;
        bus0.loadn = 1'b1; bus0.enable = 1'b0; bus0.up = 1'b1; bus0.data = 8'h00;
        bus1.loadn = 1'b1; bus1.enable = 1'b0; bus1.up = 1'b1; bus1.data = 8'h00;
        @(negedge clk);
        #1;

        //    sel clr ldn en up data    count tc zero done
        step(1'b0,1'b1,1'b1,1'b0,1'b1,8'h00, 8'h00,1'b0,1'b1,1'b0, "reset0");
        step(1'b0,1'b0,1'b0,1'b0,1'b1,8'h40, 8'h40,1'b0,1'b0,1'b0, "load40");
        step(1'b0,1'b0,1'b0,1'b0,1'b1,8'h02, 8'h02,1'b0,1'b0,1'b0, "load02");
        step(1'b0,1'b0,1'b1,1'b1,1'b0,8'h00, 8'h01,1'b0,1'b0,1'b0, "down_01");
        step(1'b0,1'b0,1'b1,1'b1,1'b0,8'h00, 8'h00,1'b1,1'b1,1'b1, "down_00_done");
        step(1'b0,1'b0,1'b1,1'b1,1'b0,8'h00, 8'h00,1'b1,1'b1,1'b1, "stop_hold");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00,1'b0,1'b1,1'b0, "load0_clears_done");
        step(1'b0,1'b0,1'b0,1'b0,1'b1,8'h58, 8'h58,1'b0,1'b0,1'b0, "load58");
        step(1'b0,1'b0,1'b1,1'b1,1'b1,8'h00, 8'h59,1'b1,1'b0,1'b0, "up_59_tc");
        step(1'b0,1'b0,1'b1,1'b1,1'b1,8'h00, 8'h00,1'b0,1'b1,1'b0, "up_wrap");
        step(1'b0,1'b0,1'b0,1'b0,1'b1,8'h09, 8'h09,1'b0,1'b0,1'b0, "load09");
        step(1'b0,1'b0,1'b1,1'b1,1'b1,8'h00, 8'h10,1'b0,1'b0,1'b0, "cascade_10");
        step(1'b0,1'b0,1'b1,1'b1,1'b0,8'h00, 8'h09,1'b0,1'b0,1'b0, "dir_down_09");
        step(1'b0,1'b0,1'b1,1'b1,1'b1,8'h00, 8'h10,1'b0,1'b0,1'b0, "dir_up_10");
        step(1'b0,1'b0,1'b0,1'b0,1'b1,8'h7C, 8'h59,1'b0,1'b0,1'b0, "sat_load_7C");
        step(1'b0,1'b0,1'b0,1'b0,1'b1,8'h33, 8'h33,1'b0,1'b0,1'b0, "load33");
        step(1'b0,1'b1,1'b0,1'b1,1'b1,8'h45, 8'h00,1'b0,1'b1,1'b0, "clr_wins");
        step(1'b0,1'b0,1'b0,1'b1,1'b1,8'h27, 8'h27,1'b0,1'b0,1'b0, "load_beats_count");
        step(1'b0,1'b0,1'b1,1'b0,1'b1,8'h00, 8'h27,1'b0,1'b0,1'b0, "hold");
        step(1'b0,1'b0,1'b0,1'b0,1'b1,8'h01, 8'h01,1'b0,1'b0,1'b0, "load01");
        step(1'b0,1'b0,1'b1,1'b1,1'b0,8'h00, 8'h00,1'b1,1'b1,1'b1, "down_done_again");
        step(1'b0,1'b1,1'b1,1'b0,1'b1,8'h00, 8'h00,1'b0,1'b1,1'b0, "clr_clears_done");
        step(1'b0,1'b0,1'b1,1'b1,1'b1,8'h00, 8'h01,1'b0,1'b0,1'b0, "up_from_0");

        step(1'b1,1'b1,1'b1,1'b0,1'b1,8'h00, 8'h00,1'b0,1'b1,1'b0, "reset1");
        step(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00,1'b0,1'b1,1'b0, "w_load00");
        step(1'b1,1'b0,1'b1,1'b1,1'b0,8'h00, 8'h59,1'b0,1'b0,1'b0, "w_down_wrap");
        step(1'b1,1'b0,1'b1,1'b1,1'b0,8'h00, 8'h58,1'b0,1'b0,1'b0, "w_down_58");
        step(1'b1,1'b0,1'b0,1'b0,1'b0,8'h01, 8'h01,1'b0,1'b0,1'b0, "w_load01");
        step(1'b1,1'b0,1'b1,1'b1,1'b0,8'h00, 8'h00,1'b1,1'b1,1'b1, "w_down_done");
        step(1'b1,1'b0,1'b1,1'b1,1'b0,8'h00, 8'h59,1'b0,1'b0,1'b1, "w_wrap_done_sticky");

        @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
